// File: rtl/kb_line_buffer_if.sv
// rtl/kb_line_buffer_if.sv - key-event, decoder and line-read signals of the line buffer
interface kb_line_buffer_if #(
   parameter int AW = 4
);
   logic          key_valid;
   logic [8:0]    last_change;
   logic [8:0]    dec_code;
   logic [7:0]    dec_ascii;
   logic          line_ready;
   logic          rd_en;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic [AW:0]   len;
   logic          overflow;
   logic          key_drop;

   modport slave (
      input  key_valid, last_change, dec_ascii, rd_en,
      output dec_code, line_ready, rd_data, rd_valid, len, overflow, key_drop
   );

   modport master (
      output key_valid, last_change, dec_ascii, rd_en,
      input  dec_code, line_ready, rd_data, rd_valid, len, overflow, key_drop
   );
endinterface

// File: rtl/kb_line_buffer.sv
// rtl/kb_line_buffer.sv - sequences the scancode decoder, edits a character line, hands it to a reader
module kb_line_buffer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   kb_line_buffer_if.slave    bus
);
   localparam logic [8:0]  C_ENTER = 9'h05A;
   localparam logic [8:0]  C_BKSP  = 9'h066;
   localparam logic [AW:0] C_FULL  = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_READY} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [8:0]    r_dec_code;
   logic [7:0]    r_rd_data;
   logic          r_rd_valid;
   logic [AW:0]   r_len;
   logic [AW:0]   r_rd_ptr;
   logic          r_overflow;
   logic          r_key_drop;
   logic [7:0]    r_mem [DEPTH];
   logic          w_line_ready;

   logic w_is_enter;
   logic w_is_bksp;
   logic w_printable;
   logic w_has_room;
   logic w_do_write;
   logic w_last_rd;

   assign w_is_enter  = (r_dec_code == C_ENTER);
   assign w_is_bksp   = (r_dec_code == C_BKSP);
   assign w_printable = (bus.dec_ascii != 8'd0);
   assign w_has_room  = (r_len < C_FULL);
   assign w_do_write  = (r_state == S_LOOKUP) && !w_is_enter && !w_is_bksp
                        && w_printable && w_has_room;
   // Full-width compare so a line of exactly DEPTH characters ends on the right read.
   assign w_last_rd   = (r_rd_ptr == (r_len - (AW+1)'(1)));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (bus.key_valid) w_next = S_LOOKUP;
         S_LOOKUP: w_next = (w_is_enter && (r_len != '0)) ? S_READY : S_IDLE;
         S_READY:  if (bus.rd_en && w_last_rd) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_line_ready = (r_state == S_READY);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_dec_code <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_len      <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
         r_key_drop <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         r_key_drop <= bus.key_valid && (r_state != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (bus.key_valid) r_dec_code <= bus.last_change;
            end
            S_LOOKUP: begin
               if (w_is_enter) begin
                  if (r_len != '0) r_rd_ptr <= '0;
               end else if (w_is_bksp) begin
                  if (r_len != '0) r_len <= r_len - (AW+1)'(1);
               end else if (w_printable) begin
                  if (w_has_room) r_len <= r_len + (AW+1)'(1);
                  else            r_overflow <= 1'b1;
               end
            end
            S_READY: begin
               if (bus.rd_en) begin
                  r_rd_data  <= r_mem[r_rd_ptr[AW-1:0]];
                  r_rd_valid <= 1'b1;
                  r_rd_ptr   <= r_rd_ptr + (AW+1)'(1);
                  if (w_last_rd) begin
                     r_len      <= '0;
                     r_overflow <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_write) r_mem[r_len[AW-1:0]] <= bus.dec_ascii;
   end

   assign bus.dec_code   = r_dec_code;
   assign bus.line_ready = w_line_ready;
   assign bus.rd_data    = r_rd_data;
   assign bus.rd_valid   = r_rd_valid;
   assign bus.len        = r_len;
   assign bus.overflow   = r_overflow;
   assign bus.key_drop   = r_key_drop;
endmodule

// File: tb/tb_kb_line_buffer.sv
// tb/tb_kb_line_buffer.sv - randomized bench for kb_line_buffer against a line-editing model
module tb_kb_line_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   kb_line_buffer_if #(.AW(4)) bus();

   kb_line_buffer #(.DEPTH(16), .AW(4)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Stand-in for the scancode decoder; Enter/Backspace deliberately map to nonzero ASCII.
   function automatic logic [7:0] ascii_of(input logic [8:0] c);
      case (c)
         9'h01C: return 8'h41;
         9'h032: return 8'h42;
         9'h021: return 8'h43;
         9'h023: return 8'h44;
         9'h024: return 8'h45;
         9'h02B: return 8'h46;
         9'h034: return 8'h47;
         9'h033: return 8'h48;
         9'h043: return 8'h49;
         9'h03B: return 8'h4A;
         9'h05A: return 8'h0D;
         9'h066: return 8'h08;
         default: return 8'h00;
      endcase
   endfunction

   assign bus.dec_ascii = ascii_of(bus.dec_code);

   logic [8:0] pcodes [10] = '{9'h01C, 9'h032, 9'h021, 9'h023, 9'h024,
                               9'h02B, 9'h034, 9'h033, 9'h043, 9'h03B};

   logic [7:0] m_line [$];
   bit         m_ovf;
   bit         m_ready;
   logic [7:0] got_q [$];
   int         got_miss;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_key(input logic [8:0] code);
      logic [7:0] a;
      a = ascii_of(code);
      if (code == 9'h05A) begin
         if (m_line.size() > 0) m_ready = 1;
      end else if (code == 9'h066) begin
         if (m_line.size() > 0) void'(m_line.pop_back());
      end else if (a != 8'd0) begin
         if (m_line.size() < 16) m_line.push_back(a);
         else                    m_ovf = 1;
      end
   endtask

   task automatic model_clear();
      m_line.delete();
      m_ready = 0;
      m_ovf   = 0;
   endtask

   // One key press with 3-cycle spacing; ends one cycle after the buffer update is visible.
   task automatic press(input logic [8:0] code);
      bus.key_valid   = 1'b1;
      bus.last_change = code;
      tick();
      bus.key_valid   = 1'b0;
      tick();
      model_key(code);
      tick();
   endtask

   task automatic drain(input int n);
      got_q.delete();
      got_miss = 0;
      bus.rd_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus.rd_valid === 1'b1) got_q.push_back(bus.rd_data);
         else                       got_miss++;
      end
      bus.rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      n_total++; if ({bus.dec_code, bus.line_ready, bus.rd_data, bus.rd_valid, bus.len, bus.overflow, bus.key_drop} !== 33'd0)
         $display("FAIL reset_outputs got dc=%h lr=%b rd=%h rv=%b len=%0d ov=%b kd=%b want all 0", bus.dec_code, bus.line_ready, bus.rd_data, bus.rd_valid, bus.len, bus.overflow, bus.key_drop);
      else n_pass++;
      rst = 1'b0;
      tick();
      model_clear();
   endtask

   task automatic test_basic();
      press(9'h01C);
      n_total++; if (bus.dec_code !== 9'h01C) $display("FAIL basic_dec_code got %h want 01c", bus.dec_code); else n_pass++;
      press(9'h032);
      press(9'h021);
      n_total++; if (bus.len !== 5'd3) $display("FAIL basic_len got %0d want 3", bus.len); else n_pass++;
      press(9'h05A);
      n_total++; if (bus.line_ready !== 1'b1) $display("FAIL basic_ready got %b want 1", bus.line_ready); else n_pass++;
      drain(3);
      n_total++; if (got_miss != 0 || got_q.size() != 3) $display("FAIL basic_rd_count got %0d want 3", got_q.size()); else n_pass++;
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
         n_total++; if (got_q[i] !== 8'd65 + 8'(i)) $display("FAIL basic_rd_data[%0d] got %0d want %0d", i, got_q[i], 65 + i); else n_pass++;
      end
      n_total++; if (bus.line_ready !== 1'b0 || bus.len !== 5'd0) $display("FAIL basic_after_drain got lr=%b len=%0d want 0 0", bus.line_ready, bus.len); else n_pass++;
      tick();
      n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL basic_rv_end got %b want 0", bus.rd_valid); else n_pass++;
      model_clear();
   endtask

   task automatic test_backspace();
      press(9'h01C); press(9'h032); press(9'h066); press(9'h023);
      n_total++; if (bus.len !== 5'(m_line.size())) $display("FAIL bs_len got %0d want %0d", bus.len, m_line.size()); else n_pass++;
      press(9'h05A);
      drain(m_line.size());
      n_total++; if (got_q.size() != 2 || got_q[0] !== 8'd65 || got_q[1] !== 8'd68)
         $display("FAIL bs_read got n=%0d want 65,68", got_q.size());
      else n_pass++;
      model_clear();
      press(9'h066);
      n_total++; if (bus.len !== 5'd0) $display("FAIL bs_empty got %0d want 0", bus.len); else n_pass++;
      press(9'h05A);
      n_total++; if (bus.line_ready !== 1'b0) $display("FAIL enter_empty got %b want 0", bus.line_ready); else n_pass++;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 17; i++) press(pcodes[$urandom_range(9)]);
      n_total++; if (bus.len !== 5'd16 || bus.overflow !== 1'b1) $display("FAIL ovf_full got len=%0d ov=%b want 16 1", bus.len, bus.overflow); else n_pass++;
      press(9'h05A);
      drain(16);
      n_total++; if (got_q.size() != 16) $display("FAIL ovf_count got %0d want 16", got_q.size()); else n_pass++;
      for (int i = 0; i < got_q.size(); i++) begin
         n_total++; if (got_q[i] !== m_line[i]) $display("FAIL ovf_data[%0d] got %h want %h", i, got_q[i], m_line[i]); else n_pass++;
      end
      n_total++; if (bus.overflow !== 1'b0 || bus.len !== 5'd0) $display("FAIL ovf_clear got ov=%b len=%0d want 0 0", bus.overflow, bus.len); else n_pass++;
      model_clear();
   endtask

   task automatic test_unmapped();
      press(9'h01C);
      press(9'h076);
      n_total++; if (bus.len !== 5'd1 || bus.overflow !== 1'b0) $display("FAIL unmapped got len=%0d ov=%b want 1 0", bus.len, bus.overflow); else n_pass++;
   endtask

   task automatic test_back_to_back();
      bus.key_valid = 1'b1; bus.last_change = 9'h032;
      tick();
      bus.last_change = 9'h021;
      tick();
      bus.key_valid = 1'b0;
      model_key(9'h032);
      n_total++; if (bus.key_drop !== 1'b1) $display("FAIL b2b_drop got %b want 1", bus.key_drop); else n_pass++;
      n_total++; if (bus.dec_code !== 9'h032 || bus.len !== 5'(m_line.size())) $display("FAIL b2b_state got dc=%h len=%0d want 032 %0d", bus.dec_code, bus.len, m_line.size()); else n_pass++;
      tick();
      n_total++; if (bus.key_drop !== 1'b0) $display("FAIL b2b_pulse got %b want 0", bus.key_drop); else n_pass++;
   endtask

   task automatic test_ready_drop();
      press(9'h05A);
      bus.key_valid = 1'b1; bus.last_change = 9'h024;
      tick();
      bus.key_valid = 1'b0;
      n_total++; if (bus.key_drop !== 1'b1 || bus.line_ready !== 1'b1 || bus.dec_code !== 9'h05A)
         $display("FAIL ready_drop got kd=%b lr=%b dc=%h want 1 1 05a", bus.key_drop, bus.line_ready, bus.dec_code);
      else n_pass++;
      tick();
      drain(m_line.size());
      n_total++; if (got_q != m_line) $display("FAIL ready_drop_data got n=%0d want n=%0d", got_q.size(), m_line.size()); else n_pass++;
      model_clear();
   endtask

   task automatic test_idle_rd();
      int seen = 0;
      bus.rd_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.rd_valid === 1'b1) seen++;
      end
      bus.rd_en = 1'b0;
      n_total++; if (seen != 0) $display("FAIL idle_rd got %0d pulses want 0", seen); else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      press(9'h01C); press(9'h032); press(9'h021); press(9'h05A);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      n_total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'd65) $display("FAIL midrd_first got rv=%b rd=%0d want 1 65", bus.rd_valid, bus.rd_data); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_total++; if (bus.line_ready !== 1'b0 || bus.len !== 5'd0 || bus.rd_valid !== 1'b0 || bus.dec_code !== 9'd0)
         $display("FAIL midrd_reset got lr=%b len=%0d rv=%b dc=%h want 0 0 0 0", bus.line_ready, bus.len, bus.rd_valid, bus.dec_code);
      else n_pass++;
      tick();
      rst = 1'b0;
      tick();
      model_clear();
      for (int i = 0; i < 4; i++) press(pcodes[$urandom_range(9)]);
      press(9'h05A);
      drain(4);
      n_total++; if (got_q != m_line) $display("FAIL midrd_next got n=%0d want n=%0d", got_q.size(), m_line.size()); else n_pass++;
      model_clear();
   endtask

   task automatic test_random();
      logic [8:0] code;
      int         r;
      for (int k = 0; k < 60; k++) begin
         r = $urandom_range(9);
         if (r < 6)       code = pcodes[$urandom_range(9)];
         else if (r == 6) code = 9'h066;
         else if (r == 7) code = 9'h076;
         else             code = 9'h05A;
         press(code);
         n_total++; if (bus.len !== 5'(m_line.size()) || bus.overflow !== m_ovf || bus.line_ready !== m_ready)
            $display("FAIL rand_state[%0d] got len=%0d ov=%b lr=%b want %0d %b %b", k, bus.len, bus.overflow, bus.line_ready, m_line.size(), m_ovf, m_ready);
         else n_pass++;
         if (m_ready) begin
            drain(m_line.size());
            n_total++; if (got_q != m_line || got_miss != 0) $display("FAIL rand_line[%0d] got n=%0d want n=%0d", k, got_q.size(), m_line.size()); else n_pass++;
            model_clear();
            tick();
         end
      end
   endtask

   initial begin
      bus.key_valid   = 1'b0;
      bus.last_change = 9'd0;
      bus.rd_en       = 1'b0;
      test_reset();
      test_basic();
      test_backspace();
      test_overflow();
      test_unmapped();
      test_back_to_back();
      test_ready_drop();
      test_idle_rd();
      test_reset_mid_read();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
